// File: rtl/mem_req_sched.sv
// mem_req_sched: schedules ICache fetches, LSB loads and buffered committed stores
// onto a single byte-serial memory engine port, and routes results back.
// Ports:
//   clk, rst_in (async active-low), rdy_in (global enable), flush, io_buffer_full
//   lsb_req_*  : LSB load/store request in, lsb_req_ready out
//   lsb_load_* : registered 1-cycle load result pulse
//   ic_req_*   : ICache fetch request in, ic_req_ready out
//   ic_resp_*  : registered 1-cycle fetch result pulse
//   eng_req_*  : engine command out, eng_req_ready/eng_done/eng_rdata in
//   sb_count   : store-buffer occupancy; busy : any work outstanding
module mem_req_sched #(
  parameter int unsigned SB_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned LSB_ID_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             flush,
  input  logic                             io_buffer_full,
  input  logic                             lsb_req_valid,
  input  logic                             lsb_req_we,
  input  logic [31:0]                      lsb_req_addr,
  input  logic [31:0]                      lsb_req_wdata,
  input  logic [1:0]                       lsb_req_size,
  input  logic [LSB_ID_WIDTH-1:0]          lsb_req_id,
  output logic                             lsb_req_ready,
  output logic                             lsb_load_valid,
  output logic [LSB_ID_WIDTH-1:0]          lsb_load_id,
  output logic [31:0]                      lsb_load_data,
  input  logic                             ic_req_valid,
  input  logic [31:0]                      ic_req_addr,
  output logic                             ic_req_ready,
  output logic                             ic_resp_valid,
  output logic [31:0]                      ic_resp_addr,
  output logic [31:0]                      ic_resp_inst,
  output logic                             eng_req_valid,
  output logic                             eng_req_we,
  output logic [31:0]                      eng_req_addr,
  output logic [31:0]                      eng_req_wdata,
  output logic [1:0]                       eng_req_size,
  input  logic                             eng_req_ready,
  input  logic                             eng_done,
  input  logic [31:0]                      eng_rdata,
  output logic [$clog2(SB_DEPTH):0]        sb_count,
  output logic                             busy
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OP_LD, OP_ST, OP_IF} op_t;

  state_t             state;
  op_t                cur_op;
  logic               drop;
  logic [31:0]        rdata_q;

  logic [31:0]        sb_addr  [SB_DEPTH];
  logic [31:0]        sb_wdata [SB_DEPTH];
  logic [1:0]         sb_size  [SB_DEPTH];
  logic [PTR_W-1:0]   sb_head, sb_tail;

  logic                    ld_pend;
  logic [31:0]             ld_addr;
  logic [1:0]              ld_size;
  logic [LSB_ID_WIDTH-1:0] ld_id;
  logic                    if_pend;
  logic [31:0]             if_addr;
  logic [STV_W-1:0]        starve_cnt;

  logic sb_full, ld_hit, ld_ok, st_ok, if_ok, grant;
  op_t  grant_op;
  logic st_acc, ld_acc, if_acc, sb_pop, ld_clr, if_clr, withdraw;

  assign sb_full       = (sb_count == CNT_W'(SB_DEPTH));
  assign lsb_req_ready = lsb_req_we ? !sb_full : !ld_pend;
  assign ic_req_ready  = !if_pend;
  assign busy          = (state != S_IDLE) || (sb_count != '0) || ld_pend || if_pend;

  // Request acceptance, SB pop and pend-flag completion
  always_comb begin
    st_acc   = rdy_in && !flush && lsb_req_valid && lsb_req_we && !sb_full;
    ld_acc   = rdy_in && !flush && lsb_req_valid && !lsb_req_we && !ld_pend;
    if_acc   = rdy_in && !flush && ic_req_valid && !if_pend;
    sb_pop   = rdy_in && (state == S_ISSUE) && (cur_op == OP_ST) && eng_req_ready;
    ld_clr   = (state == S_WAIT) && eng_done && (cur_op == OP_LD) && !drop;
    if_clr   = (state == S_WAIT) && eng_done && (cur_op == OP_IF) && !drop;
    withdraw = (state == S_ISSUE) && flush && (cur_op != OP_ST) && !eng_req_ready;
  end

  // Hazard check and arbitration for the IDLE grant
  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if ((CNT_W'(i) < sb_count) &&
          (sb_addr[sb_head + PTR_W'(i)][31:2] == ld_addr[31:2]))
        ld_hit = 1'b1;
    end
    // IO-range loads must not overtake any buffered store
    ld_ok = ld_pend && !flush && !ld_hit &&
            !((ld_addr[31:16] == 16'h0003) && (sb_count != '0));
    // Head store to the UART waits out back-pressure, keeping FIFO order
    st_ok = (sb_count != '0) &&
            !((sb_addr[sb_head] == 32'h0003_0000) && io_buffer_full);
    if_ok = if_pend && !flush;

    grant    = 1'b0;
    grant_op = OP_LD;
    if (if_ok && (starve_cnt >= STV_W'(STARVE_LIMIT))) begin
      grant = 1'b1; grant_op = OP_IF;
    end else if (sb_full && st_ok) begin
      grant = 1'b1; grant_op = OP_ST;
    end else if (ld_ok) begin
      grant = 1'b1; grant_op = OP_LD;
    end else if (st_ok) begin
      grant = 1'b1; grant_op = OP_ST;
    end else if (if_ok) begin
      grant = 1'b1; grant_op = OP_IF;
    end
  end

  // Store-buffer payload storage (contents need no reset)
  always_ff @(posedge clk) begin
    if (st_acc) begin
      sb_addr[sb_tail]  <= lsb_req_addr;
      sb_wdata[sb_tail] <= lsb_req_wdata;
      sb_size[sb_tail]  <= lsb_req_size;
    end
  end

  // Control state, request capture, FSM and registered outputs
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state          <= S_IDLE;
      cur_op         <= OP_LD;
      drop           <= 1'b0;
      rdata_q        <= '0;
      sb_head        <= '0;
      sb_tail        <= '0;
      sb_count       <= '0;
      ld_pend        <= 1'b0;
      ld_addr        <= '0;
      ld_size        <= '0;
      ld_id          <= '0;
      if_pend        <= 1'b0;
      if_addr        <= '0;
      starve_cnt     <= '0;
      lsb_load_valid <= 1'b0;
      lsb_load_id    <= '0;
      lsb_load_data  <= '0;
      ic_resp_valid  <= 1'b0;
      ic_resp_addr   <= '0;
      ic_resp_inst   <= '0;
      eng_req_valid  <= 1'b0;
      eng_req_we     <= 1'b0;
      eng_req_addr   <= '0;
      eng_req_wdata  <= '0;
      eng_req_size   <= '0;
    end else if (rdy_in) begin
      lsb_load_valid <= 1'b0;
      ic_resp_valid  <= 1'b0;

      if (st_acc) sb_tail <= sb_tail + PTR_W'(1);
      if (sb_pop) sb_head <= sb_head + PTR_W'(1);
      sb_count <= sb_count + CNT_W'(st_acc) - CNT_W'(sb_pop);

      if (ld_acc) begin
        ld_pend <= 1'b1;
        ld_addr <= lsb_req_addr;
        ld_size <= lsb_req_size;
        ld_id   <= lsb_req_id;
      end else if (flush || ld_clr) begin
        ld_pend <= 1'b0;
      end

      if (if_acc) begin
        if_pend <= 1'b1;
        if_addr <= ic_req_addr;
      end else if (flush || if_clr) begin
        if_pend <= 1'b0;
      end

      if (flush) begin
        starve_cnt <= '0;
      end else if (state == S_IDLE) begin
        if (!if_pend || (grant && grant_op == OP_IF))
          starve_cnt <= '0;
        else if (starve_cnt != STV_W'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + STV_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (grant) begin
            state         <= S_ISSUE;
            cur_op        <= grant_op;
            drop          <= 1'b0;
            eng_req_valid <= 1'b1;
            case (grant_op)
              OP_ST: begin
                eng_req_we    <= 1'b1;
                eng_req_addr  <= sb_addr[sb_head];
                eng_req_wdata <= sb_wdata[sb_head];
                eng_req_size  <= sb_size[sb_head];
              end
              OP_IF: begin
                eng_req_we    <= 1'b0;
                eng_req_addr  <= if_addr;
                eng_req_wdata <= '0;
                eng_req_size  <= 2'd2;
              end
              default: begin
                eng_req_we    <= 1'b0;
                eng_req_addr  <= ld_addr;
                eng_req_wdata <= '0;
                eng_req_size  <= ld_size;
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (eng_req_ready) begin
            eng_req_valid <= 1'b0;
            state         <= S_WAIT;
            // Engine already took the command: let it finish, discard result
            if (flush && cur_op != OP_ST) drop <= 1'b1;
          end else if (withdraw) begin
            eng_req_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (flush && cur_op != OP_ST) drop <= 1'b1;
          if (eng_done) begin
            rdata_q <= eng_rdata;
            state   <= S_RESP;
          end
        end
        default: begin
          state <= S_IDLE;
          if (!drop && !flush) begin
            if (cur_op == OP_LD) begin
              lsb_load_valid <= 1'b1;
              lsb_load_id    <= ld_id;
              lsb_load_data  <= rdata_q;
            end else if (cur_op == OP_IF) begin
              ic_resp_valid <= 1'b1;
              ic_resp_addr  <= if_addr;
              ic_resp_inst  <= rdata_q;
            end
          end
        end
      endcase
    end
  end

endmodule
